// File: rtl/rv32i_lsu_if.sv
// rtl/rv32i_lsu_if.sv - execute-stage request/response and data-memory bundle for rv32i_lsu
interface rv32i_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        memory_write;
  logic        memory_read;
  logic [31:0] memory_address;
  logic [3:0]  memory_byteenable;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_wdata, memory_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output memory_write, memory_read, memory_address, memory_byteenable, memory_write_data
  );

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_wdata, memory_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  memory_write, memory_read, memory_address, memory_byteenable, memory_write_data
  );
endinterface

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - single-outstanding RV32I load/store unit with lane steering and extension
module rv32i_lsu (
  input  logic       clk,
  input  logic       reset,
  rv32i_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, LOAD_WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        r_resp_error;
  logic [31:0] r_resp_rdata;
  logic        r_mem_write;
  logic        r_mem_read;
  logic [31:0] r_mem_address;
  logic [3:0]  r_mem_byteenable;
  logic [31:0] r_mem_write_data;

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_error;
  logic [3:0]  w_byteenable;
  logic [31:0] w_write_data;
  logic [7:0]  w_load_byte;
  logic [15:0] w_load_half;
  logic [31:0] w_load_data;

  always_comb begin : decode
    if (bus.req_write) w_illegal = bus.req_funct3 > 3'd2;
    else               w_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 >= 3'd6);
    // funct3[1:0] encodes access size for every legal load and store
    w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_address[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_address[1:0] != 2'b00));
    w_error = w_illegal || w_misaligned;
    case (bus.req_funct3[1:0])
      2'b00: begin
        w_byteenable = 4'b0001 << bus.req_address[1:0];
        w_write_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_byteenable = 4'b0011 << bus.req_address[1:0];
        w_write_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_byteenable = 4'b1111;
        w_write_data = bus.req_wdata;
      end
    endcase
  end

  always_comb begin : load_extract
    case (r_lane)
      2'd0:    w_load_byte = bus.memory_read_data[7:0];
      2'd1:    w_load_byte = bus.memory_read_data[15:8];
      2'd2:    w_load_byte = bus.memory_read_data[23:16];
      default: w_load_byte = bus.memory_read_data[31:24];
    endcase
    w_load_half = r_lane[1] ? bus.memory_read_data[31:16] : bus.memory_read_data[15:0];
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
      3'd1:    w_load_data = {{16{w_load_half[15]}}, w_load_half};
      3'd4:    w_load_data = {24'b0, w_load_byte};
      3'd5:    w_load_data = {16'b0, w_load_half};
      default: w_load_data = bus.memory_read_data;
    endcase
  end

  always_comb begin : next_state
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (bus.req_valid) w_next_state = w_error ? RESP : ISSUE;
      ISSUE:     w_next_state = r_write ? RESP : LOAD_WAIT;
      LOAD_WAIT: w_next_state = RESP;
      RESP:      w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_write          <= 1'b0;
      r_funct3         <= 3'd0;
      r_lane           <= 2'd0;
      r_resp_error     <= 1'b0;
      r_resp_rdata     <= '0;
      r_mem_write      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_address    <= '0;
      r_mem_byteenable <= 4'b0000;
      r_mem_write_data <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_write          <= bus.req_write;
          r_funct3         <= bus.req_funct3;
          r_lane           <= bus.req_address[1:0];
          r_resp_rdata     <= '0;
          r_resp_error     <= w_error;
          r_mem_write      <= !w_error && bus.req_write;
          r_mem_read       <= !w_error && !bus.req_write;
          r_mem_address    <= w_error ? '0 : {bus.req_address[31:2], 2'b00};
          r_mem_byteenable <= (!w_error && bus.req_write) ? w_byteenable : 4'b0000;
          r_mem_write_data <= (!w_error && bus.req_write) ? w_write_data : '0;
        end
        ISSUE: begin
          r_mem_write      <= 1'b0;
          r_mem_read       <= 1'b0;
          r_mem_address    <= '0;
          r_mem_byteenable <= 4'b0000;
          r_mem_write_data <= '0;
        end
        LOAD_WAIT: r_resp_rdata <= w_load_data;
        default: ;
      endcase
    end
  end

  assign bus.req_ready         = (r_state == IDLE);
  assign bus.resp_valid        = (r_state == RESP);
  assign bus.resp_rdata        = r_resp_rdata;
  assign bus.resp_error        = r_resp_error;
  assign bus.memory_write      = r_mem_write;
  assign bus.memory_read       = r_mem_read;
  assign bus.memory_address    = r_mem_address;
  assign bus.memory_byteenable = r_mem_byteenable;
  assign bus.memory_write_data = r_mem_write_data;
endmodule

// File: tb/tb_rv32i_lsu.sv
// tb/tb_rv32i_lsu.sv - randomized and directed bench for rv32i_lsu against a byte-level reference model
module tb_rv32i_lsu;
  logic clk;
  logic reset;
  rv32i_lsu_if bus ();

  rv32i_lsu dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference memory is byte-addressed; the responder memory is word-based and lane-merged
  logic [7:0]  ref_bytes [0:63];
  logic [31:0] phys [0:15];

  int          cyc = 0;
  bit          model_on = 0;
  int          ready_cyc = 0;
  int          issue_cyc = -10;
  int          resp_cyc = -10;
  logic        exp_w, exp_r, exp_err;
  logic [31:0] exp_addr, exp_wd, exp_rd;
  logic [3:0]  exp_be;

  task automatic model_accept();
    int size;
    int base;
    bit sgn;
    bit err;
    logic [31:0] a, wd, v;
    a = bus.req_address;
    wd = bus.req_wdata;
    size = 0;
    sgn = 0;
    if (bus.req_write) begin
      case (bus.req_funct3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (bus.req_funct3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    err = (size == 0) || ((int'(a[1:0]) % size) != 0);
    if (err) begin
      issue_cyc = -10;
      resp_cyc = cyc;
      ready_cyc = cyc + 1;
      exp_rd = 0;
      exp_err = 1;
    end else begin
      issue_cyc = cyc;
      exp_addr = {a[31:2], 2'b00};
      exp_err = 0;
      base = int'(a[5:0]);
      if (bus.req_write) begin
        exp_w = 1;
        exp_r = 0;
        exp_be = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << a[1:0]);
        exp_wd = (size == 1) ? {24'b0, wd[7:0]} * 32'h01010101 :
                 (size == 2) ? {16'b0, wd[15:0]} * 32'h00010001 : wd;
        for (int i = 0; i < size; i++) ref_bytes[base + i] = wd[8*i +: 8];
        exp_rd = 0;
        resp_cyc = cyc + 1;
        ready_cyc = cyc + 2;
      end else begin
        exp_w = 0;
        exp_r = 1;
        exp_be = 4'b0000;
        v = 0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[base + i];
        if (sgn && size == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sgn && size == 2 && v[15]) v = v | 32'hFFFF0000;
        exp_rd = v;
        resp_cyc = cyc + 2;
        ready_cyc = cyc + 3;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_on = 1;
      ready_cyc = cyc;
      issue_cyc = -10;
      resp_cyc = -10;
      exp_rd = 0;
      exp_err = 0;
    end else if (model_on && bus.req_valid && (cyc - 1) >= ready_cyc) begin
      model_accept();
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      check1("req_ready", bus.req_ready, cyc >= ready_cyc);
      check1("resp_valid", bus.resp_valid, cyc == resp_cyc);
      if (cyc >= resp_cyc) begin
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check1("resp_error", bus.resp_error, exp_err);
      end
      if (cyc == issue_cyc) begin
        check1("memory_write", bus.memory_write, exp_w);
        check1("memory_read", bus.memory_read, exp_r);
        check("memory_address", bus.memory_address, exp_addr);
        check("memory_byteenable", {28'b0, bus.memory_byteenable}, {28'b0, exp_be});
        if (exp_w) check("memory_write_data", bus.memory_write_data, exp_wd);
      end else begin
        check1("idle memory_write", bus.memory_write, 1'b0);
        check1("idle memory_read", bus.memory_read, 1'b0);
      end
    end
  end

  // Read data appears only during the cycle after memory_read; garbage otherwise
  logic [31:0] pend;
  bit          have_pend = 0;
  initial forever begin
    @(negedge clk);
    if (have_pend) begin
      bus.memory_read_data = pend;
      have_pend = 0;
    end else begin
      bus.memory_read_data = $urandom;
    end
    if (bus.memory_read) begin
      pend = phys[bus.memory_address[5:2]];
      have_pend = 1;
    end
    if (bus.memory_write)
      for (int b = 0; b < 4; b++)
        if (bus.memory_byteenable[b])
          phys[bus.memory_address[5:2]][8*b +: 8] = bus.memory_write_data[8*b +: 8];
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.req_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    check1("wait_ready", bus.req_ready, 1'b1);
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_funct3 = f3;
    bus.req_address = a;
    bus.req_wdata = wd;
  endtask

  task automatic directed(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, input logic [31:0] rd, input logic er,
                          input logic [31:0] maddr, input logic [3:0] be, input logic [31:0] mwd);
    int k;
    wait_ready();
    drive(w, f3, a, wd);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check1({nm, " memory_write"}, bus.memory_write, w && !er);
    check1({nm, " memory_read"}, bus.memory_read, !w && !er);
    if (!er) begin
      check({nm, " memory_address"}, bus.memory_address, maddr);
      check({nm, " byteenable"}, {28'b0, bus.memory_byteenable}, {28'b0, be});
      if (w) check({nm, " write_data"}, bus.memory_write_data, mwd);
    end
    k = 1;
    while (!bus.resp_valid && k < 6) begin
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, k, lat);
    check({nm, " rdata"}, bus.resp_rdata, rd);
    check1({nm, " error"}, bus.resp_error, er);
    @(negedge clk);
    check1({nm, " pulse end"}, bus.resp_valid, 1'b0);
  endtask

  initial begin
    int nresp;
    logic [31:0] addr;
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'($urandom);
    ref_bytes[0] = 8'hBB;
    ref_bytes[1] = 8'hAA;
    ref_bytes[2] = 8'h99;
    ref_bytes[3] = 8'h88;
    for (int w = 0; w < 16; w++)
      phys[w] = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_address = '0;
    bus.req_wdata = '0;
    bus.memory_read_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset req_ready", bus.req_ready, 1'b1);
    check1("reset resp_valid", bus.resp_valid, 1'b0);
    check("reset resp_rdata", bus.resp_rdata, 32'h0);
    check("reset memory_address", bus.memory_address, 32'h0);
    check("reset byteenable", {28'b0, bus.memory_byteenable}, 32'h0);
    reset = 1'b0;

    directed("LB 101",  1'b0, 3'd0, 32'h101, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 32'h100, 4'b0000, 32'h0);
    directed("LHU 102", 1'b0, 3'd5, 32'h102, 32'h0, 3, 32'h00008899, 1'b0, 32'h100, 4'b0000, 32'h0);
    directed("LBU 103", 1'b0, 3'd4, 32'h103, 32'h0, 3, 32'h00000088, 1'b0, 32'h100, 4'b0000, 32'h0);
    directed("LW 100",  1'b0, 3'd2, 32'h100, 32'h0, 3, 32'h8899AABB, 1'b0, 32'h100, 4'b0000, 32'h0);
    directed("SB 103",  1'b1, 3'd0, 32'h103, 32'h12345678, 2, 32'h0, 1'b0, 32'h100, 4'b1000, 32'h78787878);
    directed("LW after SB", 1'b0, 3'd2, 32'h100, 32'h0, 3, 32'h7899AABB, 1'b0, 32'h100, 4'b0000, 32'h0);
    directed("LW 102",  1'b0, 3'd2, 32'h102, 32'h0, 1, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    directed("SH 101",  1'b1, 3'd1, 32'h101, 32'hFFFF, 1, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    directed("SH 106",  1'b1, 3'd1, 32'h106, 32'hCAFEBEEF, 2, 32'h0, 1'b0, 32'h104, 4'b1100, 32'hBEEFBEEF);
    directed("LH 106",  1'b0, 3'd1, 32'h106, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 32'h104, 4'b0000, 32'h0);
    directed("store f3=3", 1'b1, 3'd3, 32'h100, 32'h1, 1, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);

    wait_ready();
    drive(1'b0, 3'd2, 32'h100, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("abort resp_valid", bus.resp_valid, 1'b0);
    check1("abort memory_read", bus.memory_read, 1'b0);
    check("abort rdata", bus.resp_rdata, 32'h0);
    check1("abort req_ready", bus.req_ready, 1'b1);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check1("abort no resp", bus.resp_valid, 1'b0);
    end
    directed("LBU after abort", 1'b0, 3'd4, 32'h101, 32'h0, 3, 32'h000000AA, 1'b0, 32'h100, 4'b0000, 32'h0);

    wait_ready();
    drive(1'b0, 3'd2, 32'h104, 32'h0);
    nresp = 0;
    for (int i = 0; i < 12; i++) begin
      check1("b2b req_ready", bus.req_ready, (i % 4) == 0);
      if (bus.resp_valid) nresp++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b responses", nresp, 3);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom);
      bus.req_valid = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    reset = 1'b0;
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
